// File: rtl/cisc_bus_pkg.sv
// Shared types and constants for the CPU external-bus arbiter.
package cisc_bus_pkg;

  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 8;
  localparam int unsigned CW   = 8;
  localparam int unsigned PW   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned RQ_FETCH = 0;
  localparam int unsigned RQ_OPND  = 1;
  localparam int unsigned RQ_DMA   = 2;

  localparam logic [DW-1:0] TIMEOUT_RDATA = 8'hFF;

  // Payload captured from the winning requester at arbitration time
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } xfer_t;

  function automatic logic [PW-1:0] oh2idx(input logic [NREQ-1:0] oh);
    logic [PW-1:0] idx;
    idx = PW'(RQ_FETCH);
    if (oh[RQ_OPND]) idx = PW'(RQ_OPND);
    if (oh[RQ_DMA])  idx = PW'(RQ_DMA);
    return idx;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
    return (idx >= PW'(RQ_DMA)) ? PW'(RQ_FETCH) : PW'(idx + PW'(1));
  endfunction

endpackage

// File: rtl/cisc_bus_arbiter_rr_pick3.sv
// Combinational rotating-priority picker for three requesters.
module rr_pick3
  import cisc_bus_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win_c
);

  logic f, o, d;

  assign f = req[RQ_FETCH];
  assign o = req[RQ_OPND];
  assign d = req[RQ_DMA];

  // An out-of-range pointer falls back to fetch-first order
  always_comb begin
    win_c = '0;
    unique case (ptr)
      PW'(RQ_OPND): begin
        if (o)      win_c[RQ_OPND]  = 1'b1;
        else if (d) win_c[RQ_DMA]   = 1'b1;
        else if (f) win_c[RQ_FETCH] = 1'b1;
      end
      PW'(RQ_DMA): begin
        if (d)      win_c[RQ_DMA]   = 1'b1;
        else if (f) win_c[RQ_FETCH] = 1'b1;
        else if (o) win_c[RQ_OPND]  = 1'b1;
      end
      default: begin
        if (f)      win_c[RQ_FETCH] = 1'b1;
        else if (o) win_c[RQ_OPND]  = 1'b1;
        else if (d) win_c[RQ_DMA]   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cisc_bus_arbiter.sv
// Three-way bus arbiter and address/data/strobe sequencer for the external 8-bit bus.
module cisc_bus_arbiter
  import cisc_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] we,
  input  logic [AW-1:0]   addr0,
  input  logic [AW-1:0]   addr1,
  input  logic [AW-1:0]   addr2,
  input  logic [DW-1:0]   wdata0,
  input  logic [DW-1:0]   wdata1,
  input  logic [DW-1:0]   wdata2,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            err,
  output logic [DW-1:0]   rdata,
  output logic [AW-1:0]   eab,
  output logic [DW-1:0]   edb_out,
  output logic            edb_oe,
  input  logic [DW-1:0]   edb_in,
  output logic            mem_rd,
  output logic            mem_wr,
  input  logic            mem_rdy
);

  state_t          state, state_nxt;
  logic [NREQ-1:0] win, win_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            abort, abort_nxt;
  logic [DW-1:0]   rbuf, rbuf_nxt;
  xfer_t           cur, cur_nxt;
  xfer_t           pick_xfer;
  logic [NREQ-1:0] pick_c;

  logic [NREQ-1:0] gnt_nxt, done_nxt;
  logic            err_nxt, edb_oe_nxt, mem_rd_nxt, mem_wr_nxt;
  logic [DW-1:0]   rdata_nxt, edb_out_nxt;
  logic [AW-1:0]   eab_nxt;

  rr_pick3 u_pick (
    .req   (req),
    .ptr   (ptr),
    .win_c (pick_c)
  );

  // Payload of whichever requester the picker selects this cycle
  always_comb begin
    pick_xfer = '0;
    if (pick_c[RQ_FETCH])
      pick_xfer = '{we: we[RQ_FETCH], addr: addr0, wdata: wdata0};
    else if (pick_c[RQ_OPND])
      pick_xfer = '{we: we[RQ_OPND], addr: addr1, wdata: wdata1};
    else if (pick_c[RQ_DMA])
      pick_xfer = '{we: we[RQ_DMA], addr: addr2, wdata: wdata2};
  end

  // Next-state and next-output logic; output registers follow the current state by one cycle
  always_comb begin
    state_nxt   = state;
    win_nxt     = win;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    abort_nxt   = abort;
    rbuf_nxt    = rbuf;
    cur_nxt     = cur;
    gnt_nxt     = gnt;
    done_nxt    = '0;
    err_nxt     = 1'b0;
    rdata_nxt   = rdata;
    eab_nxt     = eab;
    edb_out_nxt = edb_out;
    edb_oe_nxt  = 1'b0;
    mem_rd_nxt  = 1'b0;
    mem_wr_nxt  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        gnt_nxt = '0;
        if (|req) begin
          win_nxt   = pick_c;
          cur_nxt   = pick_xfer;
          state_nxt = ST_ADDR;
        end
      end

      ST_ADDR: begin
        gnt_nxt = win;
        eab_nxt = cur.addr;
        if (cur.we) begin
          edb_out_nxt = cur.wdata;
          edb_oe_nxt  = 1'b1;
        end
        state_nxt = ST_WAIT;
      end

      ST_WAIT: begin
        gnt_nxt    = win;
        edb_oe_nxt = cur.we;
        mem_rd_nxt = ~cur.we;
        mem_wr_nxt = cur.we;
        if (mem_rdy) begin
          if (!cur.we) rbuf_nxt = edb_in;
          state_nxt = ST_DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          abort_nxt = 1'b1;
          rbuf_nxt  = TIMEOUT_RDATA;
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = CW'(cnt + CW'(1));
        end
      end

      ST_DONE: begin
        gnt_nxt   = win;
        done_nxt  = win;
        err_nxt   = abort;
        rdata_nxt = rbuf;
        ptr_nxt   = next_ptr(oh2idx(win));
        cnt_nxt   = '0;
        abort_nxt = 1'b0;
        state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, control and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      win     <= '0;
      ptr     <= '0;
      cnt     <= '0;
      abort   <= 1'b0;
      rbuf    <= '0;
      cur     <= '0;
      gnt     <= '0;
      done    <= '0;
      err     <= 1'b0;
      rdata   <= '0;
      eab     <= '0;
      edb_out <= '0;
      edb_oe  <= 1'b0;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
    end else begin
      state   <= state_nxt;
      win     <= win_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
      abort   <= abort_nxt;
      rbuf    <= rbuf_nxt;
      cur     <= cur_nxt;
      gnt     <= gnt_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      rdata   <= rdata_nxt;
      eab     <= eab_nxt;
      edb_out <= edb_out_nxt;
      edb_oe  <= edb_oe_nxt;
      mem_rd  <= mem_rd_nxt;
      mem_wr  <= mem_wr_nxt;
    end
  end

endmodule

// File: tb/tb_cisc_bus_arbiter.sv
// Self-checking bench: directed and randomized transfers against a transaction-level model.
module tb_cisc_bus_arbiter;

  localparam int TO = 4;

  logic       clk, reset;
  logic [2:0] req, we;
  logic [7:0] addr0, addr1, addr2, wdata0, wdata1, wdata2;
  logic [2:0] gnt, done;
  logic       err;
  logic [7:0] rdata, eab, edb_out, edb_in;
  logic       edb_oe, mem_rd, mem_wr, mem_rdy;

  int checks = 0;
  int errors = 0;
  int mptr   = 0;
  logic [7:0] mrdata = 8'h00;

  cisc_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .eab(eab), .edb_out(edb_out), .edb_oe(edb_oe), .edb_in(edb_in),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdy(mem_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Rotating priority: first requesting index starting at the pointer
  function automatic int pick_model(input logic [2:0] r, input int p);
    for (int k = 0; k < 3; k++)
      if (r[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction

  function automatic logic [7:0] addr_of(input int w);
    return (w == 0) ? addr0 : (w == 1) ? addr1 : addr2;
  endfunction

  function automatic logic [7:0] wdata_of(input int w);
    return (w == 0) ? wdata0 : (w == 1) ? wdata1 : wdata2;
  endfunction

  task automatic chk_zero_all(input string tag);
    chk({tag, "_gnt"}, 8'(gnt), 8'h00);
    chk({tag, "_done"}, 8'(done), 8'h00);
    chk({tag, "_err"}, 8'(err), 8'h00);
    chk({tag, "_rd"}, 8'(mem_rd), 8'h00);
    chk({tag, "_wr"}, 8'(mem_wr), 8'h00);
    chk({tag, "_oe"}, 8'(edb_oe), 8'h00);
    chk({tag, "_eab"}, eab, 8'h00);
    chk({tag, "_edbout"}, edb_out, 8'h00);
    chk({tag, "_rdata"}, rdata, 8'h00);
  endtask

  // One transfer starting from IDLE. nwait = WAIT cycle (1-based) on which mem_rdy is high;
  // 0 or >TO means memory never answers.
  task automatic do_xfer(input logic [2:0] reqv, input int nwait, input logic [7:0] din,
                         input bit drop, input bit jitter);
    int w, d;
    bit tmo;
    logic wr;
    logic [7:0] a, wd, exp_rd, oh;
    req    = reqv;
    w      = pick_model(reqv, mptr);
    wr     = we[w];
    a      = addr_of(w);
    wd     = wdata_of(w);
    oh     = 8'(1 << w);
    tmo    = (nwait < 1) || (nwait > TO);
    d      = tmo ? TO : nwait;
    exp_rd = tmo ? 8'hFF : (wr ? mrdata : din);
    mem_rdy = 1'($urandom);
    step();
    chk("idle_gnt", 8'(gnt), 8'h00);
    chk("idle_done", 8'(done), 8'h00);
    mem_rdy = 1'($urandom);
    step();
    chk("addr_gnt", 8'(gnt), oh);
    chk("addr_eab", eab, a);
    chk("addr_oe", 8'(edb_oe), 8'(wr));
    if (wr) chk("addr_edbout", edb_out, wd);
    chk("addr_strobes", 8'({mem_rd, mem_wr}), 8'h00);
    for (int k = 1; k <= d; k++) begin
      mem_rdy = !tmo && (k == nwait);
      edb_in  = mem_rdy ? din : 8'($urandom);
      if (drop && k == 1) req[w] = 1'b0;
      if (jitter) req = (req & 3'(oh)) | (3'($urandom) & ~3'(oh));
      step();
      chk("wait_gnt", 8'(gnt), oh);
      chk("wait_eab", eab, a);
      chk("wait_rd", 8'(mem_rd), 8'(!wr));
      chk("wait_wr", 8'(mem_wr), 8'(wr));
      chk("wait_oe", 8'(edb_oe), 8'(wr));
      if (wr) chk("wait_edbout", edb_out, wd);
      chk("wait_done", 8'(done), 8'h00);
      chk("wait_err", 8'(err), 8'h00);
    end
    mem_rdy = 1'($urandom);
    edb_in  = 8'($urandom);
    step();
    chk("done_pulse", 8'(done), oh);
    chk("done_err", 8'(err), 8'(tmo));
    chk("done_rdata", rdata, exp_rd);
    chk("done_gnt", 8'(gnt), oh);
    chk("done_strobes", 8'({mem_rd, mem_wr, edb_oe}), 8'h00);
    mrdata = exp_rd;
    mptr   = (w + 1) % 3;
  endtask

  task automatic idle_check();
    req = 3'b000;
    step();
    chk("idle_after_gnt", 8'(gnt), 8'h00);
    chk("idle_after_done", 8'(done), 8'h00);
    chk("idle_after_strobes", 8'({mem_rd, mem_wr}), 8'h00);
  endtask

  initial begin
    reset = 1'b1; req = '0; we = '0; mem_rdy = 1'b0; edb_in = '0;
    addr0 = '0; addr1 = '0; addr2 = '0; wdata0 = '0; wdata1 = '0; wdata2 = '0;
    #12;
    chk_zero_all("reset");
    step();
    reset = 1'b0;

    // Single fetch read with immediate ready
    we = 3'b000; addr0 = 8'h20;
    do_xfer(3'b001, 1, 8'h5A, 1'b0, 1'b0);

    // DMA write with three wait cycles
    we = 3'b100; addr2 = 8'h80; wdata2 = 8'hC3;
    do_xfer(3'b100, 3, 8'h00, 1'b0, 1'b0);

    // Contention: all three held, rotating order
    we = 3'b000; addr0 = 8'h11; addr1 = 8'h22; addr2 = 8'h33;
    for (int i = 0; i < 4; i++) do_xfer(3'b111, 1, 8'(8'h40 + i), 1'b0, 1'b0);

    // Timeout read from operand requester
    addr1 = 8'h9C;
    do_xfer(3'b010, 0, 8'h00, 1'b0, 1'b0);

    // Ready on the last cycle before timeout still succeeds
    addr1 = 8'h9D;
    do_xfer(3'b110, TO, 8'h77, 1'b0, 1'b0);

    // Fetch request dropped mid-transfer still completes
    addr0 = 8'h05;
    do_xfer(3'b001, 2, 8'h3E, 1'b1, 1'b0);
    idle_check();

    // Async reset while in WAIT, then fetch must beat operand
    we = 3'b000; addr2 = 8'h44; req = 3'b100;
    step();
    step();
    mem_rdy = 1'b0;
    step();
    #3 reset = 1'b1;
    #1;
    chk_zero_all("async_rst");
    @(posedge clk);
    #2 reset = 1'b0;
    mptr = 0; mrdata = 8'h00; req = 3'b000;
    do_xfer(3'b011, 1, 8'hA5, 1'b0, 1'b0);

    // Randomized transfers
    for (int i = 0; i < 40; i++) begin
      we     = 3'($urandom);
      addr0  = 8'($urandom); addr1  = 8'($urandom); addr2  = 8'($urandom);
      wdata0 = 8'($urandom); wdata1 = 8'($urandom); wdata2 = 8'($urandom);
      do_xfer(3'($urandom_range(1, 7)), int'($urandom_range(0, TO + 1)),
              8'($urandom), 1'b0, 1'b1);
    end
    idle_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
